// File: rtl/dd_issue_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dd_issue_arbiter
// Description : Round-robin issue arbiter sharing one pipelined GRU
//               gate-derivative datapath among NREQ hidden-unit requesters.
//               Registered operand drive, LAT-deep tag pipe that routes each
//               returned result to its requester and flags issue/return
//               mismatches on a sticky error output.
//               Optional macro DD_ARB_STATS_EN adds issue_cnt / stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module dd_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATABIT = 16,
    parameter int HTNUM   = 64,
    parameter int LAT     = 6,
    parameter int TAGW    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      halt,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATABIT-1:0]   req_rorz,
    input  logic [NREQ*HTNUM-1:0]     req_w,
    input  logic [NREQ*4*DATABIT-1:0] req_dh,
    output logic [NREQ-1:0]           gnt,
    output logic                      dp_en,
    output logic [DATABIT-1:0]        dp_rorz,
    output logic [HTNUM-1:0]          dp_w,
    output logic [DATABIT-1:0]        dp_dh0,
    output logic [DATABIT-1:0]        dp_dh1,
    output logic [DATABIT-1:0]        dp_dh2,
    output logic [DATABIT-1:0]        dp_dh3,
    input  logic                      dp_valid,
    input  logic [DATABIT-1:0]        dp_out,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATABIT-1:0]        rsp_data,
`ifdef DD_ARB_STATS_EN
    output logic [31:0]               issue_cnt,
    output logic [31:0]               stall_cnt,
`endif
    output logic                      err
);

    localparam logic [NREQ-1:0] c_one      = NREQ'(1);
    localparam logic [TAGW-1:0] c_last_rst = TAGW'(NREQ - 1);

    // Arbitration state and winner
    logic [TAGW-1:0]      r_last;
    logic                 w_win;
    logic [TAGW-1:0]      w_win_idx;
    logic [TAGW-1:0]      w_cand;

    // Issue registers
    logic                 r_dp_en;
    logic [TAGW-1:0]      r_dp_idx;
    logic [DATABIT-1:0]   r_dp_rorz;
    logic [HTNUM-1:0]     r_dp_w;
    logic [4*DATABIT-1:0] r_dp_dh;

    // Tag pipe
    logic [LAT-1:0]       r_tag_vld;
    logic [TAGW-1:0]      r_tag_idx [LAT];
    logic                 w_head_vld;
    logic [TAGW-1:0]      w_head_idx;

    // Return registers
    logic [NREQ-1:0]      r_rsp_valid;
    logic [DATABIT-1:0]   r_rsp_data;
    logic                 r_err;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        int j;
        j         = 0;
        w_cand    = '0;
        w_win     = 1'b0;
        w_win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(r_last) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            w_cand = TAGW'(j);
            if (!w_win && req[w_cand]) begin
                w_win     = 1'b1;
                w_win_idx = w_cand;
            end
        end
        if (halt || rst) begin
            w_win = 1'b0;
        end
    end

    assign gnt = w_win ? (c_one << w_win_idx) : '0;

    // Latch the winner's operands and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= c_last_rst;
            r_dp_en   <= 1'b0;
            r_dp_idx  <= '0;
            r_dp_rorz <= '0;
            r_dp_w    <= '0;
            r_dp_dh   <= '0;
        end else begin
            r_dp_en <= w_win;
            if (w_win) begin
                r_last    <= w_win_idx;
                r_dp_idx  <= w_win_idx;
                r_dp_rorz <= req_rorz[w_win_idx*DATABIT +: DATABIT];
                r_dp_w    <= req_w[w_win_idx*HTNUM +: HTNUM];
                r_dp_dh   <= req_dh[w_win_idx*4*DATABIT +: 4*DATABIT];
            end
        end
    end

    assign dp_en   = r_dp_en;
    assign dp_rorz = r_dp_rorz;
    assign dp_w    = r_dp_w;
    assign dp_dh0  = r_dp_dh[0*DATABIT +: DATABIT];
    assign dp_dh1  = r_dp_dh[1*DATABIT +: DATABIT];
    assign dp_dh2  = r_dp_dh[2*DATABIT +: DATABIT];
    assign dp_dh3  = r_dp_dh[3*DATABIT +: DATABIT];

    // Shift issued tags alongside the datapath so the head meets dp_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_dp_en;
            r_tag_idx[0] <= r_dp_idx;
            for (int i = 1; i < LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    assign w_head_vld = r_tag_vld[LAT-1];
    assign w_head_idx = r_tag_idx[LAT-1];

    // Route matched returns to their requester; any mismatch sets sticky err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_head_vld && dp_valid) begin
                r_rsp_valid <= c_one << w_head_idx;
                r_rsp_data  <= dp_out;
            end
            if (w_head_vld != dp_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err       = r_err;

`ifdef DD_ARB_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating counters of issue cycles and requested-but-ungranted cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_dp_en && (r_issue_cnt != 32'hFFFF_FFFF)) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if ((|req) && !w_win && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dd_issue_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dd_issue_arbiter
// Description : Scoreboard bench for dd_issue_arbiter. Stimulus computes the
//               expected grant/issue/response from the round-robin rules and
//               queues them; a monitor pops and compares; a behavioural
//               datapath returns results LAT cycles after each issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dd_issue_arbiter;

    localparam int NREQ    = 4;
    localparam int DATABIT = 16;
    localparam int HTNUM   = 64;
    localparam int LAT     = 6;
    localparam int TAGW    = 2;
    localparam int NEVER   = 32'h7fff_ffff;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      halt = 1'b0;
    logic [NREQ-1:0]           req = '0;
    logic [NREQ*DATABIT-1:0]   req_rorz = '0;
    logic [NREQ*HTNUM-1:0]     req_w = '0;
    logic [NREQ*4*DATABIT-1:0] req_dh = '0;
    logic [NREQ-1:0]           gnt;
    logic                      dp_en;
    logic [DATABIT-1:0]        dp_rorz, dp_dh0, dp_dh1, dp_dh2, dp_dh3;
    logic [HTNUM-1:0]          dp_w;
    logic                      dp_valid = 1'b0;
    logic [DATABIT-1:0]        dp_out = '0;
    logic [NREQ-1:0]           rsp_valid;
    logic [DATABIT-1:0]        rsp_data;
    logic                      err;
`ifdef DD_ARB_STATS_EN
    logic [31:0]               issue_cnt, stall_cnt;
`endif

    dd_issue_arbiter #(
        .NREQ(NREQ), .DATABIT(DATABIT), .HTNUM(HTNUM), .LAT(LAT), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt), .req(req),
        .req_rorz(req_rorz), .req_w(req_w), .req_dh(req_dh),
        .gnt(gnt), .dp_en(dp_en), .dp_rorz(dp_rorz), .dp_w(dp_w),
        .dp_dh0(dp_dh0), .dp_dh1(dp_dh1), .dp_dh2(dp_dh2), .dp_dh3(dp_dh3),
        .dp_valid(dp_valid), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef DD_ARB_STATS_EN
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int idx; logic [15:0] rorz; logic [63:0] w; logic [63:0] dh; } iss_t;
    typedef struct { int due; int idx; logic [15:0] data; } rsp_t;
    typedef struct { int due; logic [15:0] data; } dpq_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    dpq_t dpq[$];
    int   drop_q[$];

    int  cyc = 0;
    int  nvec = 0;
    int  nfail = 0;
    int  err_from = NEVER;
    bit  drop_req = 1'b0;
    bit  spur_req = 1'b0;
    int  m_last = NREQ - 1;
    int  m_issue = 0;
    int  m_stall = 0;
    logic [NREQ-1:0] pend = '0;
    logic [15:0] last_rorz = '0;
    logic [63:0] last_w = '0;
    logic [63:0] last_dh = '0;
    logic [15:0] last_data = '0;

    // Stand-in for the datapath arithmetic: any operand-sensitive function works
    function automatic logic [15:0] f_dd(input logic [15:0] r, input logic [63:0] w, input logic [63:0] dh);
        logic [15:0] s;
        s = r ^ {dh[7:0], dh[15:8]};
        s = s + dh[31:16] * 16'd3 + dh[47:32] * 16'd5 + dh[63:48] * 16'd7;
        s = s ^ w[15:0] ^ {w[23:16], w[31:24]};
        s = s + w[47:32] * 16'd11 + w[63:48] * 16'd13;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: returns f_dd of the issued operands LAT cycles later
    always @(negedge clk) begin
        dpq_t dq;
        if (dp_en === 1'b1) begin
            dpq.push_back('{cyc + LAT, f_dd(dp_rorz, dp_w, {dp_dh3, dp_dh2, dp_dh1, dp_dh0})});
        end
        dp_valid = 1'b0;
        dp_out   = 16'($urandom);
        if (dpq.size() > 0 && dpq[0].due == cyc) begin
            dq = dpq.pop_front();
            if (drop_req) begin
                drop_req = 1'b0;
                drop_q.push_back(cyc + 1);
                if (err_from == NEVER) err_from = cyc + 1;
            end else begin
                dp_valid = 1'b1;
                dp_out   = dq.data;
            end
        end else if (spur_req) begin
            spur_req = 1'b0;
            dp_valid = 1'b1;
            dp_out   = 16'h1234;
            if (err_from == NEVER) err_from = cyc + 1;
        end
    end

    // Monitor: pops scoreboard entries and compares registered outputs
    always @(negedge clk) begin
        iss_t mi;
        rsp_t mr;
        logic [NREQ-1:0] erv;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            mi = iss_q.pop_front();
            chk("dp_en", dp_en, 1);
            chk("dp_rorz", dp_rorz, mi.rorz);
            chk("dp_w", dp_w, mi.w);
            chk("dp_dh", {dp_dh3, dp_dh2, dp_dh1, dp_dh0}, mi.dh);
            last_rorz = mi.rorz;
            last_w    = mi.w;
            last_dh   = mi.dh;
        end else begin
            chk("dp_en_idle", dp_en, 0);
            chk("dp_rorz_hold", dp_rorz, last_rorz);
            chk("dp_w_hold", dp_w, last_w);
            chk("dp_dh_hold", {dp_dh3, dp_dh2, dp_dh1, dp_dh0}, last_dh);
        end
        erv = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            mr = rsp_q.pop_front();
            if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                void'(drop_q.pop_front());
            end else begin
                erv[mr.idx] = 1'b1;
                last_data   = mr.data;
            end
        end
        chk("rsp_valid", rsp_valid, erv);
        chk("rsp_data", rsp_data, last_data);
        chk("err", err, (cyc >= err_from) ? 1 : 0);
    end

    task automatic flush();
        iss_q.delete(); rsp_q.delete(); dpq.delete(); drop_q.delete();
        err_from = NEVER; drop_req = 1'b0; spur_req = 1'b0;
        last_rorz = '0; last_w = '0; last_dh = '0; last_data = '0;
        m_last = NREQ - 1; m_issue = 0; m_stall = 0;
    endtask

    // One cycle of stimulus plus the reference grant decision
    task automatic step(input bit r, input bit h, input logic [NREQ-1:0] rq, input bit rops);
        logic [NREQ-1:0] eg;
        int wi;
        @(negedge clk);
        #1;
        rst = r; halt = h; req = rq;
        if (rops) begin
            for (int i = 0; i < NREQ; i++) begin
                req_rorz[i*DATABIT +: DATABIT]   = 16'($urandom);
                req_w[i*HTNUM +: HTNUM]          = {$urandom, $urandom};
                req_dh[i*4*DATABIT +: 4*DATABIT] = {$urandom, $urandom};
            end
        end
        #1;
        eg = '0;
        wi = -1;
        if (!r && !h) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (wi < 0 && rq[j]) wi = j;
            end
        end
        if (wi >= 0) eg[wi] = 1'b1;
        chk("gnt", gnt, eg);
        if (r) begin
            flush();
        end else begin
            if ((|rq) && wi < 0) m_stall++;
            if (wi >= 0) begin
                iss_q.push_back('{cyc + 1, wi, req_rorz[wi*DATABIT +: DATABIT],
                                  req_w[wi*HTNUM +: HTNUM], req_dh[wi*4*DATABIT +: 4*DATABIT]});
                rsp_q.push_back('{cyc + 2 + LAT, wi,
                                  f_dd(req_rorz[wi*DATABIT +: DATABIT], req_w[wi*HTNUM +: HTNUM],
                                       req_dh[wi*4*DATABIT +: 4*DATABIT])});
                m_last = wi;
                m_issue++;
            end
        end
        pend = rq & ~eg;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        bit r, h;
        // Reset, with requests present: grant must stay low
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        idle(2);
        // Single request from requester 0 with rorz = 0.5
        req_rorz[15:0] = 16'h2000;
        step(1'b0, 1'b0, 4'b0001, 1'b0);
        idle(LAT + 3);
        // All four requesting for 8 cycles: strict rotation, back-to-back issue
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'b1111, 1'b1);
        // halt blocks grants; release grants requester 1 first
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0110, 1'b1);
        step(1'b0, 1'b0, 4'b0110, 1'b1);
        idle(LAT + 4);
        // Dropped datapath return: err sets, no response, err stays
        drop_req = 1'b1;
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        step(1'b0, 1'b0, 4'b1000, 1'b1);
        idle(LAT + 8);
        step(1'b1, 1'b0, '0, 1'b1);
        idle(3);
        // Spurious return with empty pipe
        spur_req = 1'b1;
        idle(6);
        step(1'b1, 1'b0, '0, 1'b1);
        // Reset with three ops in flight: nothing returns afterwards
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, 1'b1);
        idle(3);
        step(1'b1, 1'b0, '0, 1'b1);
        idle(LAT + 6);
        // Randomized traffic, requests held until granted
        pend = '0;
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            h  = ($urandom_range(0, 9) == 0);
            rq = pend | (4'($urandom) & 4'($urandom));
            step(r, h, rq, 1'b1);
        end
        idle(LAT + 6);
        chk("iss_q_drained", 64'(iss_q.size()), 0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 0);
`ifdef DD_ARB_STATS_EN
        chk("issue_cnt", issue_cnt, 64'(m_issue));
        chk("stall_cnt", stall_cnt, 64'(m_stall));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
